// File: rtl/rand_pkg.sv
// Shared state encoding and default constants for the ranged LFSR random source.
package rand_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    REDUCE = 2'd2
  } rand_state_t;

  localparam int          RAND_WIDTH = 16;
  localparam logic [15:0] RAND_TAPS  = 16'hB400;
  localparam logic [15:0] RAND_SEED  = 16'h00FF;
  localparam int          RAND_OUT_W = 9;

endpackage

// File: rtl/lfsr_step.sv
// Combinational Fibonacci LFSR next-state with all-zero lockup recovery to SEED.
module lfsr_step
  import rand_pkg::*;
#(
  parameter int               WIDTH = RAND_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = RAND_TAPS,
  parameter logic [WIDTH-1:0] SEED  = RAND_SEED
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  // parity[i] is the XOR of the tapped bits below position i
  logic [WIDTH:0] parity;

  assign parity[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
      assign parity[gi+1] = parity[gi] ^ (cur[gi] & TAPS[gi]);
    end
  endgenerate

  assign nxt = (cur == '0) ? SEED : {cur[WIDTH-2:0], parity[WIDTH]};

endmodule

// File: rtl/lfsr_rand_range.sv
// Request/valid random source reducing LFSR output into [lo, hi] by repeated subtraction.
// Define RAND_FREERUN_EN to let the LFSR advance every idle cycle for extra entropy.
module lfsr_rand_range
  import rand_pkg::*;
#(
  parameter int               WIDTH = RAND_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = RAND_TAPS,
  parameter logic [WIDTH-1:0] SEED  = RAND_SEED,
  parameter int               OUT_W = RAND_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [OUT_W-1:0] lo,
  input  logic [OUT_W-1:0] hi,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [OUT_W-1:0] rand_out,
  output logic             rand_valid,
  output logic             range_err,
  output logic             busy
);

  rand_state_t      state_reg;
  logic [WIDTH-1:0] lfsr_reg;
  logic [WIDTH-1:0] lfsr_next;
  logic             req_d_reg;
  logic [OUT_W-1:0] lo_r_reg;
  logic [OUT_W-1:0] hi_r_reg;
  logic [OUT_W-1:0] cand_reg;
  logic [OUT_W:0]   span_reg;
  logic             req_p;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_step (
    .cur (lfsr_reg),
    .nxt (lfsr_next)
  );

  assign req_p = req & ~req_d_reg;
  assign busy  = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      lfsr_reg   <= SEED;
      req_d_reg  <= 1'b0;
      lo_r_reg   <= '0;
      hi_r_reg   <= '0;
      cand_reg   <= '0;
      span_reg   <= '0;
      rand_out   <= '0;
      rand_valid <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      req_d_reg  <= req;
      rand_valid <= 1'b0;
      range_err  <= 1'b0;
      if (seed_load) begin
        // a reload also drops whatever request is in flight
        lfsr_reg  <= (seed_in == '0) ? SEED : seed_in;
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
`ifdef RAND_FREERUN_EN
            lfsr_reg <= lfsr_next;
`endif
            if (req_p) begin
              lo_r_reg  <= lo;
              hi_r_reg  <= hi;
              // span wraps when hi < lo; REDUCE never uses it in that case
              span_reg  <= {1'b0, hi} - {1'b0, lo} + {{OUT_W{1'b0}}, 1'b1};
              state_reg <= STEP;
            end
          end
          STEP: begin
            lfsr_reg  <= lfsr_next;
            cand_reg  <= lfsr_next[OUT_W-1:0];
            state_reg <= REDUCE;
          end
          REDUCE: begin
            if (hi_r_reg < lo_r_reg) begin
              rand_out   <= lo_r_reg;
              rand_valid <= 1'b1;
              range_err  <= 1'b1;
              state_reg  <= IDLE;
            end else if ({1'b0, cand_reg} >= span_reg) begin
              cand_reg <= cand_reg - span_reg[OUT_W-1:0];
            end else begin
              rand_out   <= lo_r_reg + cand_reg;
              rand_valid <= 1'b1;
              state_reg  <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_rand_range.sv
// Self-checking bench: directed pins plus randomized traffic against a behavioural model.
module tb_lfsr_rand_range;

  localparam int          W     = 16;
  localparam int          OW    = 9;
  localparam logic [15:0] TAPS  = 16'hB400;
  localparam logic [15:0] SEED  = 16'h00FF;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          req       = 1'b0;
  logic [OW-1:0] lo        = '0;
  logic [OW-1:0] hi        = '0;
  logic          seed_load = 1'b0;
  logic [W-1:0]  seed_in   = '0;
  logic [OW-1:0] rand_out;
  logic          rand_valid;
  logic          range_err;
  logic          busy;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int valid_cnt = 0;
  int zero_req = 0;
  int zero_seen = 0;

  // behavioural model state
  logic [W-1:0]  m_lfsr = SEED;
  logic          m_req_d = 1'b0;
  logic          m_busy = 1'b0;
  logic          m_valid = 1'b0;
  logic          m_err = 1'b0;
  logic          m_pend_err = 1'b0;
  logic [OW-1:0] m_out = '0;
  logic [OW-1:0] m_pend_out = '0;
  int            m_cnt = 0;

  always #5 clk = ~clk;

  lfsr_rand_range #(
    .WIDTH (W),
    .TAPS  (TAPS),
    .SEED  (SEED),
    .OUT_W (OW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .lo         (lo),
    .hi         (hi),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .rand_out   (rand_out),
    .rand_valid (rand_valid),
    .range_err  (range_err),
    .busy       (busy)
  );

  function automatic logic [W-1:0] model_step(input logic [W-1:0] s);
    logic fb;
    if (s == '0) return SEED;
    fb = ($countones(s & TAPS) % 2) == 1;
    return {s[W-2:0], fb};
  endfunction

  // Request outcome is computed up front: value = lo + cand mod span, done 2 + cand/span edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr  = SEED;
      m_req_d = 1'b0;
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_out   = '0;
      m_cnt   = 0;
    end else begin
      logic rp;
      int   cand;
      int   span;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (zero_seen != zero_req) begin
        m_lfsr    = '0;
        zero_seen = zero_req;
      end
      rp      = req & ~m_req_d;
      m_req_d = req;
      if (seed_load) begin
        m_lfsr = (seed_in == '0) ? SEED : seed_in;
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (rp) begin
          m_lfsr = model_step(m_lfsr);
          cand   = int'(m_lfsr[OW-1:0]);
          if (hi < lo) begin
            m_pend_out = lo;
            m_pend_err = 1'b1;
            m_cnt      = 2;
          end else begin
            span       = int'(hi) - int'(lo) + 1;
            m_pend_out = OW'(int'(lo) + cand % span);
            m_pend_err = 1'b0;
            m_cnt      = 2 + cand / span;
          end
          m_busy = 1'b1;
        end
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_busy  = 1'b0;
          m_valid = 1'b1;
          m_err   = m_pend_err;
          m_out   = m_pend_out;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one request; lat counts edges after the req_p edge until rand_valid is seen.
  task automatic do_req(input logic [OW-1:0] l, input logic [OW-1:0] h,
                        output int lat, output int val, output int err, output int busy0);
    @(negedge clk);
    lo  = l;
    hi  = h;
    req = 1'b1;
    @(negedge clk);
    req   = 1'b0;
    busy0 = int'(busy);
    lat   = -1;
    val   = -1;
    err   = -1;
    for (int n = 1; n <= 700; n++) begin
      @(negedge clk);
      if (rand_valid === 1'b1) begin
        lat = n;
        val = int'(rand_out);
        err = int'(range_err);
        break;
      end
    end
  endtask

  initial begin
    int lat, val, err, b0, v0, period;
    logic [W-1:0] s;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          tests++;
          if (rand_out !== m_out || rand_valid !== m_valid ||
              range_err !== m_err || busy !== m_busy) begin
            fails++;
            $display("FAIL cycle_check t=%0t: dut out=%0d v=%b e=%b busy=%b, model out=%0d v=%b e=%b busy=%b",
                     $time, rand_out, rand_valid, range_err, busy, m_out, m_valid, m_err, m_busy);
          end
          if (rand_valid === 1'b1) begin
            valid_cnt++;
            $display("[TB] txn t=%0t rand_out=%0d range_err=%b", $time, rand_out, range_err);
          end
        end
      end
    join_none

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_rand_out", int'(rand_out), 0);
    check("reset_busy", int'(busy), 0);

    // 00FF -> 01FE, cand 510, span 200: two subtracts, 100 + 110
    do_req(9'd100, 9'd299, lat, val, err, b0);
    check("first_value", val, 210);
    check("first_latency", lat, 4);
    check("first_busy_after_req", b0, 1);
    check("first_range_err", err, 0);

    // reset mid-operation, then full range from the reset seed
    @(negedge clk);
    lo = 9'd1; hi = 9'd1; req = 1'b1;
    repeat (3) @(negedge clk);
    req = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset_midop_busy", int'(busy), 0);
    #2 rst_n = 1'b1;
    do_req(9'd0, 9'd511, lat, val, err, b0);
    check("full_range_value", val, 510);
    check("full_range_latency", lat, 2);

    do_req(9'd50, 9'd20, lat, val, err, b0);
    check("range_err_value", val, 50);
    check("range_err_flag", err, 1);
    check("range_err_latency", lat, 2);
    @(negedge clk);
    check("range_err_one_cycle", int'(range_err), 0);

    // seed reload: zero maps to SEED
    seed_in = '0; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    check("seed_zero_lfsr", int'(dut.lfsr_reg), 16'h00FF);
    seed_in = 16'h1234; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    check("seed_1234_lfsr", int'(dut.lfsr_reg), 16'h1234);

    // 1234 -> 2469, cand 105 with span 1: long REDUCE, aborted by seed_load
    v0 = valid_cnt;
    lo = 9'd5; hi = 9'd5; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_in_reduce", int'(busy), 1);
    seed_in = 16'hACE1; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    check("abort_busy", int'(busy), 0);
    repeat (200) @(negedge clk);
    check("abort_no_valid", valid_cnt - v0, 0);

    // level req held 100 cycles gives one result
    v0 = valid_cnt;
    lo = 9'd0; hi = 9'd511; req = 1'b1;
    repeat (100) @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);
    check("held_req_one_valid", valid_cnt - v0, 1);

    // second rising edge while busy is dropped
    seed_in = 16'h1234; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    v0 = valid_cnt;
    lo = 9'd0; hi = 9'd0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    check("busy_at_second_edge", int'(busy), 1);
    req = 1'b0;
    repeat (300) @(negedge clk);
    check("second_edge_dropped", valid_cnt - v0, 1);

    // lockup recovery
    @(negedge clk);
    force dut.lfsr_reg = '0;
    zero_req = zero_req + 1;
    #1 release dut.lfsr_reg;
    do_req(9'd0, 9'd511, lat, val, err, b0);
    check("lockup_lfsr", int'(dut.lfsr_reg), 16'h00FF);
    check("lockup_value", val, 255);

    // the step rule itself has maximal period from SEED
    s = SEED;
    period = 0;
    do begin
      s = model_step(s);
      period++;
    end while (s != SEED && period < 70000);
    check("model_period", period, 65535);

    // randomized traffic, checked cycle by cycle
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = ~req;
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 7))
          0: begin lo = 9'd0; hi = 9'd511; end
          1: begin lo = 9'($urandom_range(0, 511)); hi = lo; end
          2: begin hi = 9'($urandom_range(0, 255)); lo = 9'($urandom_range(256, 511)); end
          default: begin
            lo = 9'($urandom_range(0, 255));
            hi = 9'($urandom_range(int'(lo), 511));
          end
        endcase
      end
      seed_load = ($urandom_range(0, 99) == 0);
      seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
    end
    seed_load = 1'b0;
    req = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
